tick_timer: RTL and testbench

Parametrised, run-time programmable tick generator for the stopwatch datapath. It divides `clk` by a loadable period and emits a one-cycle `tick` each period. Start/stop/clear control supports pause and resume, and a one-shot mode fires a single tick. A wrapping tick counter with a sticky overflow flag is included. It feeds the stopwatch digit counters and replaces the fixed-count millisecond pulse generator.

---
 rtl/tick_timer_pkg.sv | 17 +
 rtl/tick_timer_wrap_counter.sv | 27 ++
 rtl/tick_timer.sv | 135 +++++++++++++
 tb/tb_tick_timer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_timer_pkg.sv
// Shared constants and state type for the stopwatch tick timer.
package tick_timer_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  // 1 ms at 100 MHz; the stopwatch top uses the same constant.
  localparam int TT_DEFAULT_PERIOD = 100000;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_RUN  = STATE_RUN,
    ST_DONE = STATE_DONE
  } tt_state_e;

endpackage

// File: rtl/tick_timer_wrap_counter.sv
// Free-running incrementer with enable, synchronous clear and a sticky
// flag that records any wrap from all-ones back to zero.
module wrap_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrapped
);

  // Count enabled events; clear and reset both zero the count and the flag.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else if (en) begin
      count <= count + WIDTH'(1);
      if (&count) begin
        wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_timer.sv
// Programmable tick generator: divides clk by a loadable period, with
// start/stop/clear control, one-shot mode and a wrapping tick counter.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int DEFAULT_PERIOD = TT_DEFAULT_PERIOD,
  parameter int TCNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  oneshot,
  input  logic                  period_load,
  input  logic [CNT_WIDTH-1:0]  period_in,
  output logic                  tick,
  output logic                  running,
  output logic                  done,
  output logic [TCNT_WIDTH-1:0] tick_count,
  output logic                  overflow
);

  localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

  tt_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] active_q, active_d;
  logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
  logic                 mode_q, mode_d;
  logic                 tick_d;
  logic                 wrap_evt;

  // State, prescale count, period registers and the registered tick pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      active_q <= RST_PERIOD;
      shadow_q <= RST_PERIOD;
      mode_q   <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
      tick     <= tick_d;
    end
  end

  // Next-state logic: clear beats stop beats start; counting continues on
  // the stop edge so a stop coinciding with a wrap still ticks.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    active_d = active_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    wrap_evt = 1'b0;
    shadow_d = shadow_q;

    if (period_load) begin
      shadow_d = (period_in == '0) ? ONE : period_in;
    end

    // Outside RUN there is no period in flight, so a new period applies at once.
    if (state_q != ST_RUN) begin
      active_d = shadow_d;
    end

    if (clear) begin
      count_d = '0;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_d = ST_RUN;
            mode_d  = oneshot;
          end
        end
        ST_RUN: begin
          if (count_q >= active_q - ONE) begin
            count_d  = '0;
            tick_d   = 1'b1;
            wrap_evt = 1'b1;
            active_d = shadow_d;
            if (mode_q) begin
              state_d = ST_DONE;
            end else if (stop) begin
              state_d = ST_IDLE;
            end
          end else begin
            count_d = count_q + ONE;
            if (stop) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
            count_d = '0;
            mode_d  = oneshot;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

  wrap_counter #(
    .WIDTH(TCNT_WIDTH)
  ) u_tick_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .en      (wrap_evt),
    .count   (tick_count),
    .wrapped (overflow)
  );

endmodule

// File: tb/tb_tick_timer.sv
// Directed and randomized checks of tick_timer against a behavioural model.
module tb_tick_timer;

  localparam int CW = 16;
  localparam int TW = 4;
  localparam int DP = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          clear = 1'b0;
  logic          oneshot = 1'b0;
  logic          period_load = 1'b0;
  logic [CW-1:0] period_in = '0;
  logic          tick, running, done, overflow;
  logic [TW-1:0] tick_count;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: elapsed cycles within the period, tick total mod 16.
  bit m_run = 0, m_done = 0, m_os = 0, m_tick = 0, m_ovf = 0;
  int m_count = 0, m_period = DP, m_shadow = DP, m_ticks = 0;

  tick_timer #(
    .CNT_WIDTH(CW),
    .DEFAULT_PERIOD(DP),
    .TCNT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .oneshot(oneshot), .period_load(period_load), .period_in(period_in),
    .tick(tick), .running(running), .done(done),
    .tick_count(tick_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
    compared++;
    if (observed !== 32'(expected)) begin
      mismatched++;
      if (mismatched < 40)
        $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Apply the rules of one clock edge to the model using the current inputs.
  task automatic modelStep();
    int new_shadow;
    new_shadow = period_load ? ((period_in == 0) ? 1 : int'(period_in)) : m_shadow;
    m_tick = 0;
    if (rst) begin
      m_run = 0; m_done = 0; m_os = 0; m_ovf = 0;
      m_count = 0; m_ticks = 0; m_period = DP; m_shadow = DP;
      return;
    end
    if (!m_run) m_period = new_shadow;
    if (clear) begin
      m_count = 0; m_ticks = 0; m_ovf = 0; m_done = 0;
    end else if (m_run) begin
      if (m_count + 1 >= m_period) begin
        m_tick = 1;
        m_count = 0;
        m_ticks = (m_ticks + 1) % (1 << TW);
        if (m_ticks == 0) m_ovf = 1;
        m_period = new_shadow;
        if (m_os) begin
          m_run = 0; m_done = 1;
        end else if (stop) begin
          m_run = 0;
        end
      end else begin
        m_count++;
        if (stop) m_run = 0;
      end
    end else if (m_done) begin
      if (start) begin
        m_run = 1; m_done = 0; m_count = 0; m_os = oneshot;
      end
    end else if (start && !stop) begin
      m_run = 1; m_os = oneshot;
    end
    m_shadow = new_shadow;
  endtask

  task automatic applyStimulus(input bit r, input bit c, input bit st, input bit sp,
                               input bit os, input bit pl, input int pin);
    rst = r; clear = c; start = st; stop = sp; oneshot = os;
    period_load = pl; period_in = CW'(pin);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("tick", tick, m_tick);
    checkOutput("running", running, m_run);
    checkOutput("done", done, m_done);
    checkOutput("tick_count", tick_count, m_ticks);
    checkOutput("overflow", overflow, m_ovf);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Idle until a tick is seen; n is the number of edges it took.
  task automatic waitTick(output int n);
    n = 0;
    do begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      n++;
    end while (!tick && n < 200);
    if (!tick) checkOutput("tick_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int cnt;

    $display("[TB] reset");
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_tick_count", tick_count, 0);
    checkOutput("reset_running", running, 0);

    $display("[TB] basic run");
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("start_running", running, 1);
    waitTick(n); checkOutput("basic_gap1", n, 20); checkOutput("basic_tcnt1", tick_count, 1);
    waitTick(n); checkOutput("basic_gap2", n, 20); checkOutput("basic_tcnt2", tick_count, 2);
    waitTick(n); checkOutput("basic_gap3", n, 20); checkOutput("basic_tcnt3", tick_count, 3);

    $display("[TB] pause and resume");
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    idle(6);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("paused", running, 0);
    idle(30);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    waitTick(n); checkOutput("resume_gap", n, 13);

    $display("[TB] one-shot");
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 0);
    waitTick(n); checkOutput("oneshot_gap", n, 20);
    checkOutput("oneshot_done", done, 1);
    checkOutput("oneshot_running", running, 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (tick) cnt++;
    end
    checkOutput("oneshot_extra_ticks", cnt, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 0);
    checkOutput("oneshot_restart_done", done, 0);
    waitTick(n); checkOutput("oneshot_gap2", n, 20);
    checkOutput("oneshot_done2", done, 1);

    $display("[TB] period reload");
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    idle(9);
    applyStimulus(0, 0, 0, 0, 0, 1, 5);
    waitTick(n); checkOutput("reload_current", n, 10);
    waitTick(n); checkOutput("reload_new1", n, 5);
    waitTick(n); checkOutput("reload_new2", n, 5);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    waitTick(n); checkOutput("period0_gap1", n, 1);
    waitTick(n); checkOutput("period0_gap2", n, 1);

    $display("[TB] overflow");
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 20);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) waitTick(n);
    checkOutput("ovf_tick_count", tick_count, 0);
    checkOutput("ovf_flag", overflow, 1);
    waitTick(n);
    checkOutput("ovf_sticky", overflow, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("clear_tick_count", tick_count, 0);
    checkOutput("clear_overflow", overflow, 0);
    checkOutput("clear_running", running, 1);
    waitTick(n); checkOutput("clear_gap", n, 20);

    $display("[TB] simultaneous events and reset");
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    checkOutput("start_stop_idle", running, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 7);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    idle(10);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_tick_count", tick_count, 0);
    checkOutput("rst_tick", tick, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    waitTick(n); checkOutput("rst_period", n, 20);

    $display("[TB] random");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 15) == 0),
                    int'($urandom_range(0, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
